// File: rtl/uart_tx_engine_if.sv
// Register-file <-> UART TX engine bundle: frame parameter words in, serial line and progress out.
interface uart_tx_engine_if;
  logic [31:0] uart_data_in;
  logic [31:0] uart_baud_divisor_in;
  logic [31:0] uart_tx_control_in;
  logic        tx_out;
  logic [3:0]  bit_cnt_out;
  logic        tx_busy;

  modport master (
    output uart_data_in, uart_baud_divisor_in, uart_tx_control_in,
    input  tx_out, bit_cnt_out, tx_busy
  );

  modport slave (
    input  uart_data_in, uart_baud_divisor_in, uart_tx_control_in,
    output tx_out, bit_cnt_out, tx_busy
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART serial transmit engine: one frame at a time, all parameters latched at frame start.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_engine #(
  parameter int DATA_BITS = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_engine_if.slave bus
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd5
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   stop2nd_q, stop2nd_d;
  logic [DATA_BITS-1:0]   data_q;
  logic [31:0]            div_q;
  logic                   two_stop_q;
  logic                   tx_q, tx_d;
  logic [3:0]             bc_q, bc_d;
  logic                   start_frame;
  logic                   period_end;
  logic [31:0]            div_eff;
`ifdef UART_TX_PARITY_EN
  logic                   par_en_q, par_odd_q;
`endif

  assign start_frame = bus.uart_data_in[31] & bus.uart_tx_control_in[0];
  assign div_eff     = (bus.uart_baud_divisor_in == 32'd0) ? 32'd1 : bus.uart_baud_divisor_in;
  assign period_end  = (cnt_q == div_q - 32'd1);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = period_end ? 32'd0 : cnt_q + 32'd1;
    idx_d     = idx_q;
    stop2nd_d = stop2nd_q;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (start_frame) state_d = START;
      end
      START: if (period_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (period_end) begin
        if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (period_end) state_d = STOP;
`endif
      STOP: if (period_end) begin
        if (two_stop_q && !stop2nd_q) begin
          stop2nd_d = 1'b1;
        end else begin
          stop2nd_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        cnt_d   = 32'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Line and progress code are registered from the upcoming state so they change with it.
    tx_d = 1'b1;
    bc_d = 4'd0;
    case (state_d)
      START: tx_d = 1'b0;
      DATA: begin
        tx_d = data_q[idx_d];
        bc_d = 4'(idx_d);
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = (^data_q) ^ par_odd_q;
        bc_d = 4'd9;
      end
`endif
      STOP:    bc_d = 4'd10;
      DONE:    bc_d = 4'd8;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      idx_q      <= '0;
      stop2nd_q  <= 1'b0;
      data_q     <= '0;
      div_q      <= 32'd0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      bc_q       <= 4'd0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stop2nd_q <= stop2nd_d;
      tx_q      <= tx_d;
      bc_q      <= bc_d;
      if (state_q == IDLE && start_frame) begin
        data_q     <= bus.uart_data_in[DATA_BITS-1:0];
        div_q      <= div_eff;
        two_stop_q <= bus.uart_tx_control_in[1];
`ifdef UART_TX_PARITY_EN
        par_en_q   <= bus.uart_tx_control_in[2];
        par_odd_q  <= bus.uart_tx_control_in[3];
`endif
      end
    end
  end

  assign bus.tx_out      = tx_q;
  assign bus.bit_cnt_out = bc_q;
  assign bus.tx_busy     = (state_q != IDLE);

  logic unused_bits;
`ifdef UART_TX_PARITY_EN
  assign unused_bits = ^{bus.uart_data_in[30:DATA_BITS], bus.uart_tx_control_in[31:4]};
`else
  assign unused_bits = ^{bus.uart_data_in[30:DATA_BITS], bus.uart_tx_control_in[31:2]};
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues the expected per-clock line/progress
// samples of each frame; a monitor pops and compares them while the engine reports busy.
module tb_uart_tx_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_engine_if bif ();

  uart_tx_engine #(.DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic       tx;
    logic [3:0] bc;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] ctrl;
    logic [31:0] div;
    int          deff;
    bit          stop2;
    int          par;
    int          len;
    int          mid_at;
    int          mid_kind;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   busy_cycles = 0;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic tx, input logic [3:0] bc);
    exp_t e;
    e.tx = tx;
    e.bc = bc;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] d, input int deff, input bit stop2, input int par);
    repeat (deff) push(1'b0, 4'd0);
    for (int b = 0; b < 8; b++) repeat (deff) push(d[b], 4'(b));
    if (par >= 0) repeat (deff) push(par[0], 4'd9);
    repeat (stop2 ? 2 * deff : deff) push(1'b1, 4'd10);
    push(1'b1, 4'd8);
  endtask

  // Monitor: one expected sample per busy clock, sampled away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bif.tx_busy) begin
        busy_cycles++;
        if (exp_q.size() == 0) begin
          check("unexpected_busy", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("tx_out", {31'd0, bif.tx_out}, {31'd0, e.tx});
          check("bit_cnt_out", {28'd0, bif.bit_cnt_out}, {28'd0, e.bc});
        end
      end
    end
  end

  task automatic run_frame(input vec_t v);
    bit done = 1'b0;
    @(negedge clk);
    busy_cycles = 0;
    bif.uart_data_in         = v.data;
    bif.uart_tx_control_in   = v.ctrl;
    bif.uart_baud_divisor_in = v.div;
    push_frame(v.data[7:0], v.deff, v.stop2, v.par);
    for (int i = 0; i < v.len + 20; i++) begin
      @(negedge clk);
      #1;
      if (v.mid_kind != 0 && i == v.mid_at) begin
        if (v.mid_kind == 1) begin
          bif.uart_tx_control_in = v.ctrl & ~32'd1;
        end else begin
          bif.uart_data_in         = 32'h8000_007E;
          bif.uart_baud_divisor_in = 32'd7;
          bif.uart_tx_control_in   = 32'hF;
        end
      end
      if (!bif.tx_busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("frame_complete", {31'd0, done}, 32'd1);
    check("frame_len", busy_cycles, v.len);
    exp_q.delete();
    bif.uart_data_in       = 32'd0;
    bif.uart_tx_control_in = 32'd0;
  endtask

  initial begin
    bit seen;
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bif.uart_data_in         = 32'd0;
    bif.uart_baud_divisor_in = 32'd0;
    bif.uart_tx_control_in   = 32'd0;

    //             data           ctrl   div   deff stop2 par len mid kind
    vecs[0] = '{32'h8000_00A5, 32'h1, 32'd4, 4, 1'b0, -1, 41, 0, 0};
    vecs[1] = '{32'h8000_003C, 32'h3, 32'd2, 2, 1'b1, -1, 23, 0, 0};
`ifdef UART_TX_PARITY_EN
    vecs[2] = '{32'h8000_00A5, 32'h5, 32'd3, 3, 1'b0,  0, 34, 0, 0};
    vecs[3] = '{32'h8000_00A5, 32'hD, 32'd3, 3, 1'b0,  1, 34, 0, 0};
`else
    vecs[2] = '{32'h8000_00A5, 32'h5, 32'd3, 3, 1'b0, -1, 31, 0, 0};
    vecs[3] = '{32'h8000_00A5, 32'hD, 32'd3, 3, 1'b0, -1, 31, 0, 0};
`endif
    vecs[4] = '{32'h8000_00FF, 32'h1, 32'd0, 1, 1'b0, -1, 11, 0, 0};
    vecs[5] = '{32'h8000_005A, 32'h1, 32'd3, 3, 1'b0, -1, 31, 10, 1};
    vecs[6] = '{32'h8000_0081, 32'h1, 32'd2, 2, 1'b0, -1, 21, 7, 2};

    // Reset state
    #12;
    check("rst_tx_out", {31'd0, bif.tx_out}, 32'd1);
    check("rst_bit_cnt", {28'd0, bif.bit_cnt_out}, 32'd0);
    check("rst_busy", {31'd0, bif.tx_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) run_frame(vecs[k]);

    // Enable clear: a pending request must not start a frame
    @(negedge clk);
    bif.uart_data_in         = 32'h8000_00A5;
    bif.uart_baud_divisor_in = 32'd2;
    bif.uart_tx_control_in   = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("gated_tx_out", {31'd0, bif.tx_out}, 32'd1);
      check("gated_busy", {31'd0, bif.tx_busy}, 32'd0);
    end
    bif.uart_data_in = 32'd0;

    // Reset during DATA bit 3
    @(negedge clk);
    bif.uart_data_in         = 32'h8000_00A5;
    bif.uart_baud_divisor_in = 32'd4;
    bif.uart_tx_control_in   = 32'h1;
    push_frame(8'hA5, 4, 1'b0, -1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bif.tx_busy && bif.bit_cnt_out == 4'd3) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_bit3", {31'd0, seen}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_tx_out", {31'd0, bif.tx_out}, 32'd1);
    check("midrst_bit_cnt", {28'd0, bif.bit_cnt_out}, 32'd0);
    check("midrst_busy", {31'd0, bif.tx_busy}, 32'd0);
    exp_q.delete();
    bif.uart_data_in = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_bit_cnt", {28'd0, bif.bit_cnt_out}, 32'd0);
      check("postrst_busy", {31'd0, bif.tx_busy}, 32'd0);
    end
    run_frame('{32'h8000_0033, 32'h1, 32'd2, 2, 1'b0, -1, 21, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
